snake_head_stepper: RTL and testbench

SNAKE_HEAD_STEPPER -- requirements
Module: snake_head_stepper

---
 rtl/snake_head_stepper.sv | 149 ++++++++++++++
 tb/tb_snake_head_stepper.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
// Snake head position stepper: advances the head one grid cell every TICK_DIV
// clocks in the committed direction, with edge wrap, pause and sticky crash halt.
module snake_head_stepper #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       crash,
  input  logic [2:0] dir_in,
  input  logic       dir_lock,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [2:0] dir_cur,
  output logic       step_pulse,
  output logic       wrapped,
  output logic       halted
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       dir_pend;
  logic [2:0]       ref_dir;
  logic             tick_done;
  logic             step_commit;
  logic             is_reverse;
  logic             lock_ok;
  logic [5:0]       x_nxt;
  logic [4:0]       y_nxt;
  logic             wrap_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Crash outranks both a pause request and a step falling due in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (crash)        state_nxt = HALT;
        else if (!enable) state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halted = (state == HALT);
  end

  assign tick_done   = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign step_commit = (state == RUN) && enable && !crash && tick_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tick_cnt <= '0;
    else if ((state == RUN) && enable && !crash && !tick_done)
      tick_cnt <= tick_cnt + 1'b1;
    else
      tick_cnt <= '0;
  end

  // In a commit cycle the request is judged against the direction about to be taken
  assign ref_dir    = step_commit ? dir_pend : dir_cur;
  assign is_reverse = (dir_in[2] == ref_dir[2]) &&
                      (dir_in[2] ? (dir_in[1] != ref_dir[1]) : (dir_in[0] != ref_dir[0]));
  assign lock_ok    = dir_lock && (state != HALT) && !is_reverse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     dir_pend <= 3'b000;
    else if (lock_ok) dir_pend <= dir_in;
  end

  always_comb begin
    x_nxt    = head_x;
    y_nxt    = head_y;
    wrap_nxt = 1'b0;
    if (dir_pend[2]) begin
      if (dir_pend[1]) begin
        if (head_y == 5'(GRID_H - 1)) begin
          y_nxt    = 5'd0;
          wrap_nxt = 1'b1;
        end else begin
          y_nxt = head_y + 5'd1;
        end
      end else begin
        if (head_y == 5'd0) begin
          y_nxt    = 5'(GRID_H - 1);
          wrap_nxt = 1'b1;
        end else begin
          y_nxt = head_y - 5'd1;
        end
      end
    end else begin
      if (dir_pend[0]) begin
        if (head_x == 6'(GRID_W - 1)) begin
          x_nxt    = 6'd0;
          wrap_nxt = 1'b1;
        end else begin
          x_nxt = head_x + 6'd1;
        end
      end else begin
        if (head_x == 6'd0) begin
          x_nxt    = 6'(GRID_W - 1);
          wrap_nxt = 1'b1;
        end else begin
          x_nxt = head_x - 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_x     <= 6'(START_X);
      head_y     <= 5'(START_Y);
      dir_cur    <= 3'b000;
      step_pulse <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      step_pulse <= step_commit;
      wrapped    <= step_commit && wrap_nxt;
      if (step_commit) begin
        head_x  <= x_nxt;
        head_y  <= y_nxt;
        dir_cur <= dir_pend;
      end
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Scoreboard bench for snake_head_stepper: scenarios push the steps they expect
// (cycle, position, direction, wrap) and a monitor pops them on each step_pulse.
module tb_snake_head_stepper;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       crash;
  logic [2:0] dir_in;
  logic       dir_lock;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [2:0] dir_cur;
  logic       step_pulse;
  logic       wrapped;
  logic       halted;

  typedef struct {
    int cyc;
    int x;
    int y;
    int dir;
    int wrap;
  } step_t;

  step_t sb[$];
  int    cyc       = 0;
  int    next_step = 0;
  int    checks    = 0;
  int    errors    = 0;

  snake_head_stepper #(
    .GRID_W  (8),
    .GRID_H  (4),
    .TICK_DIV(4),
    .START_X (3),
    .START_Y (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .crash     (crash),
    .dir_in    (dir_in),
    .dir_lock  (dir_lock),
    .head_x    (head_x),
    .head_y    (head_y),
    .dir_cur   (dir_cur),
    .step_pulse(step_pulse),
    .wrapped   (wrapped),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cr, input logic lk, input logic [2:0] d);
    @(negedge clk);
    enable   = en;
    crash    = cr;
    dir_lock = lk;
    dir_in   = d;
  endtask

  task automatic pushStep(input int x, input int y, input int d, input int w);
    sb.push_back('{next_step, x, y, d, w});
    next_step += 4;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 60) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
      k++;
    end
    checkOutput("drain_timeout", sb.size(), 0);
  endtask

  task automatic checkHome(input string tag);
    checkOutput({tag, "_x"}, int'(head_x), 3);
    checkOutput({tag, "_y"}, int'(head_y), 1);
    checkOutput({tag, "_dir"}, int'(dir_cur), 0);
    checkOutput({tag, "_step"}, int'(step_pulse), 0);
    checkOutput({tag, "_wrap"}, int'(wrapped), 0);
    checkOutput({tag, "_halted"}, int'(halted), 0);
  endtask

  // Every step_pulse must match the oldest expected step, including its cycle
  always @(posedge clk) begin : monitor
    step_t e;
    #1;
    if (reset_n === 1'b1) begin
      if (step_pulse) begin
        checkOutput("step_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("step_cycle", cyc, e.cyc);
          checkOutput("step_x", int'(head_x), e.x);
          checkOutput("step_y", int'(head_y), e.y);
          checkOutput("step_dir", int'(dir_cur), e.dir);
          checkOutput("step_wrap", int'(wrapped), e.wrap);
        end
      end else begin
        checkOutput("wrap_without_step", int'(wrapped), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    crash    = 1'b0;
    dir_lock = 1'b0;
    dir_in   = 3'b000;
    repeat (3) @(negedge clk);
    checkHome("reset");
    reset_n = 1'b1;

    $display("[TB] moving left with wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    next_step = cyc + 5;
    pushStep(2, 1, 0, 0);
    pushStep(1, 1, 0, 0);
    pushStep(0, 1, 0, 0);
    pushStep(7, 1, 0, 1);
    drain();

    $display("[TB] reversal dropped, then turn down");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b001);
    pushStep(6, 1, 0, 0);
    drain();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b110);
    pushStep(6, 2, 6, 0);
    pushStep(6, 3, 6, 0);
    pushStep(6, 0, 6, 1);
    drain();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b100);
    pushStep(6, 1, 6, 0);
    drain();

    $display("[TB] request during commit judged against committed direction");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b100);
    pushStep(5, 1, 0, 0);
    pushStep(5, 0, 4, 0);
    drain();

    $display("[TB] last request wins, down accepted while committing left");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b001);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'b110);
    pushStep(4, 0, 0, 0);
    pushStep(4, 1, 6, 0);
    drain();

    $display("[TB] pause mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    next_step = cyc + 5;
    pushStep(4, 2, 6, 0);
    drain();

    $display("[TB] crash on due step");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    checkOutput("halt_entered", int'(halted), 1);
    checkOutput("halt_x", int'(head_x), 4);
    checkOutput("halt_y", int'(head_y), 2);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, i[0], 3'b000);
    checkOutput("halt_sticky", int'(halted), 1);
    checkOutput("halt_frozen_x", int'(head_x), 4);
    checkOutput("halt_frozen_y", int'(head_y), 2);
    checkOutput("halt_frozen_dir", int'(dir_cur), 6);

    $display("[TB] reset out of halt");
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    checkHome("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    next_step = cyc + 5;
    pushStep(2, 1, 0, 0);
    drain();

    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    repeat (6) @(negedge clk);
    checkOutput("no_pending_steps", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
